// File: rtl/serial_bit_source_if.sv
// Parallel word load channel into serial_bit_source.
// Handshake: a word transfers on a rising clk edge where load_valid && load_ready.
interface serial_bit_source_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;

  modport master (output load_data, output load_valid, input load_ready);
  modport slave  (input load_data, input load_valid, output load_ready);
endinterface

// File: rtl/serial_bit_source.sv
// Serializes parallel words MSB-first onto x, one bit per clk, with back-to-back streaming.
// Optional macro SERIAL_PARITY_EN appends one even-parity bit after each word.
module serial_bit_source #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  serial_bit_source_if.slave  load,
  output logic                x,
  output logic                x_valid,
  output logic [15:0]         word_count,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_d, x_valid_d;
  logic [15:0]      word_count_d;
  logic             ready_c;
`ifdef SERIAL_PARITY_EN
  logic             par_q, par_d;
`endif

  assign fsm_state = state_q;
  // Reset is folded in so the channel never looks ready while held in reset.
  assign load.load_ready = reset & ready_c;

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    x_d          = x;
    x_valid_d    = x_valid;
    word_count_d = word_count;
    ready_c      = 1'b0;
`ifdef SERIAL_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: ready_c = 1'b1;
      SHIFT: begin
        if (cnt_q != '0) begin
          x_d    = sreg_q[WIDTH-1];
          sreg_d = sreg_q << 1;
          cnt_d  = cnt_q - CW'(1);
        end else begin
`ifdef SERIAL_PARITY_EN
          state_d   = PARITY;
          x_d       = par_q;
          x_valid_d = 1'b1;
`else
          ready_c      = 1'b1;
          word_count_d = word_count + 16'd1;
          state_d      = IDLE;
          x_d          = IDLE_LEVEL;
          x_valid_d    = 1'b0;
`endif
        end
      end
`ifdef SERIAL_PARITY_EN
      PARITY: begin
        ready_c      = 1'b1;
        word_count_d = word_count + 16'd1;
        state_d      = IDLE;
        x_d          = IDLE_LEVEL;
        x_valid_d    = 1'b0;
      end
`endif
      default: state_d = IDLE;
    endcase

    // An accept overrides the retire-to-IDLE path, giving gapless streaming.
    if (ready_c && load.load_valid) begin
      state_d   = SHIFT;
      x_d       = load.load_data[WIDTH-1];
      x_valid_d = 1'b1;
      sreg_d    = load.load_data << 1;
      cnt_d     = LAST_CNT;
`ifdef SERIAL_PARITY_EN
      par_d     = ^load.load_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      x          <= IDLE_LEVEL;
      x_valid    <= 1'b0;
      word_count <= 16'd0;
`ifdef SERIAL_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      x          <= x_d;
      x_valid    <= x_valid_d;
      word_count <= word_count_d;
`ifdef SERIAL_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: expected serial stream kept as a bit queue built from accepted words.
module tb_serial_bit_source;
  localparam int   WIDTH      = 8;
  localparam logic IDLE_LEVEL = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        x, x_valid;
  logic [15:0] word_count;
  logic [1:0]  fsm_state;

  serial_bit_source_if #(.WIDTH(WIDTH)) load_if ();

  serial_bit_source #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load_if.slave),
    .x          (x),
    .x_valid    (x_valid),
    .word_count (word_count),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: bits still to appear on x (head = bit on x now), with a word-end flag per bit.
  logic [0:0]  exp_q[$];
  bit          last_q[$];
  logic [15:0] exp_wc;
  logic        exp_x, exp_xv, exp_rdy;
  bit          accepted;

  task automatic update_exp();
    exp_xv  = (exp_q.size() > 0);
    exp_x   = exp_xv ? exp_q[0][0] : IDLE_LEVEL;
    exp_rdy = reset && (exp_q.size() <= 1);
  endtask

  task automatic model_clear();
    exp_q.delete();
    last_q.delete();
    exp_wc = 16'd0;
    update_exp();
  endtask

  task automatic model_edge(input logic v, input logic [WIDTH-1:0] d);
    bit acc;
    acc = v && (exp_q.size() <= 1);
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      if (last_q.pop_front()) exp_wc = exp_wc + 16'd1;
    end
    if (acc) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        exp_q.push_back(d[i]);
        last_q.push_back(1'b0);
      end
`ifdef SERIAL_PARITY_EN
      exp_q.push_back(^d);
      last_q.push_back(1'b1);
`else
      last_q[last_q.size()-1] = 1'b1;
`endif
    end
    accepted = acc;
    update_exp();
  endtask

  // Called at a falling edge: drive inputs, advance model across the rising edge, return at next falling edge.
  task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] d);
    load_if.load_valid = v;
    load_if.load_data  = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    load_if.load_valid = 1'b0;
    load_if.load_data  = '0;
    model_clear();
    repeat (2) @(negedge clk);
    vectors++; if (x !== IDLE_LEVEL) begin miscompares++; $display("FAIL reset x got %b exp %b", x, IDLE_LEVEL); end
    vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL reset x_valid got %b exp 0", x_valid); end
    vectors++; if (word_count !== 16'd0) begin miscompares++; $display("FAIL reset word_count got %0d exp 0", word_count); end
    vectors++; if (load_if.load_ready !== 1'b0) begin miscompares++; $display("FAIL reset load_ready_in_reset got %b exp 0", load_if.load_ready); end
    reset = 1'b1;
    update_exp();
    #1;
    vectors++; if (load_if.load_ready !== 1'b1) begin miscompares++; $display("FAIL reset load_ready_after got %b exp 1", load_if.load_ready); end
    @(negedge clk);
  endtask

  task automatic test_single_word();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) drive_cycle(1'b1, 8'b0010_0100);
      else        drive_cycle(1'b0, WIDTH'($urandom));
      vectors++; if (x !== exp_x) begin miscompares++; $display("FAIL single x cyc %0d got %b exp %b", c, x, exp_x); end
      vectors++; if (x_valid !== exp_xv) begin miscompares++; $display("FAIL single x_valid cyc %0d got %b exp %b", c, x_valid, exp_xv); end
      vectors++; if (load_if.load_ready !== exp_rdy) begin miscompares++; $display("FAIL single load_ready cyc %0d got %b exp %b", c, load_if.load_ready, exp_rdy); end
      vectors++; if (word_count !== exp_wc) begin miscompares++; $display("FAIL single word_count cyc %0d got %0d exp %0d", c, word_count, exp_wc); end
    end
  endtask

  task automatic test_back_to_back();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c == 0)     drive_cycle(1'b1, 8'hA5);
      else if (!done) drive_cycle(1'b1, 8'h3C);
      else            drive_cycle(1'b0, 8'h00);
      if (c > 0 && accepted) done = 1'b1;
      vectors++; if (x !== exp_x) begin miscompares++; $display("FAIL b2b x cyc %0d got %b exp %b", c, x, exp_x); end
      vectors++; if (x_valid !== exp_xv) begin miscompares++; $display("FAIL b2b x_valid cyc %0d got %b exp %b", c, x_valid, exp_xv); end
      vectors++; if (load_if.load_ready !== exp_rdy) begin miscompares++; $display("FAIL b2b load_ready cyc %0d got %b exp %b", c, load_if.load_ready, exp_rdy); end
      vectors++; if (word_count !== exp_wc) begin miscompares++; $display("FAIL b2b word_count cyc %0d got %0d exp %0d", c, word_count, exp_wc); end
    end
    vectors++; if (!done) begin miscompares++; $display("FAIL b2b second_word_accept got 0 exp 1"); end
  endtask

  task automatic test_random();
    logic v;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      drive_cycle(v, WIDTH'($urandom));
      vectors++; if (x !== exp_x) begin miscompares++; $display("FAIL random x cyc %0d got %b exp %b", c, x, exp_x); end
      vectors++; if (x_valid !== exp_xv) begin miscompares++; $display("FAIL random x_valid cyc %0d got %b exp %b", c, x_valid, exp_xv); end
      vectors++; if (load_if.load_ready !== exp_rdy) begin miscompares++; $display("FAIL random load_ready cyc %0d got %b exp %b", c, load_if.load_ready, exp_rdy); end
      vectors++; if (word_count !== exp_wc) begin miscompares++; $display("FAIL random word_count cyc %0d got %0d exp %0d", c, word_count, exp_wc); end
    end
    for (int c = 0; c < WIDTH + 2; c++) drive_cycle(1'b0, '0);
  endtask

  task automatic test_mid_word_reset();
    drive_cycle(1'b1, 8'hFF);
    repeat (3) drive_cycle(1'b0, 8'h00);
    vectors++; if (x_valid !== 1'b1) begin miscompares++; $display("FAIL midrst x_valid_before got %b exp 1", x_valid); end
    #2 reset = 1'b0;
    model_clear();
    #1;
    vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL midrst x_valid_async got %b exp 0", x_valid); end
    vectors++; if (x !== IDLE_LEVEL) begin miscompares++; $display("FAIL midrst x_async got %b exp %b", x, IDLE_LEVEL); end
    vectors++; if (word_count !== 16'd0) begin miscompares++; $display("FAIL midrst word_count got %0d exp 0", word_count); end
    vectors++; if (load_if.load_ready !== 1'b0) begin miscompares++; $display("FAIL midrst load_ready got %b exp 0", load_if.load_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    update_exp();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) drive_cycle(1'b1, 8'h81);
      else        drive_cycle(1'b0, 8'h00);
      vectors++; if (x !== exp_x) begin miscompares++; $display("FAIL midrst_reload x cyc %0d got %b exp %b", c, x, exp_x); end
      vectors++; if (x_valid !== exp_xv) begin miscompares++; $display("FAIL midrst_reload x_valid cyc %0d got %b exp %b", c, x_valid, exp_xv); end
      vectors++; if (word_count !== exp_wc) begin miscompares++; $display("FAIL midrst_reload word_count cyc %0d got %0d exp %0d", c, word_count, exp_wc); end
    end
  endtask

`ifdef SERIAL_PARITY_EN
  task automatic test_parity();
    logic [WIDTH-1:0] words [2];
    words[0] = 8'h07;
    words[1] = 8'h03;
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < WIDTH + 3; c++) begin
        if (c == 0) drive_cycle(1'b1, words[w]);
        else        drive_cycle(1'b0, 8'h00);
        vectors++; if (x !== exp_x) begin miscompares++; $display("FAIL parity x w%0d cyc %0d got %b exp %b", w, c, x, exp_x); end
        vectors++; if (x_valid !== exp_xv) begin miscompares++; $display("FAIL parity x_valid w%0d cyc %0d got %b exp %b", w, c, x_valid, exp_xv); end
        vectors++; if (load_if.load_ready !== exp_rdy) begin miscompares++; $display("FAIL parity load_ready w%0d cyc %0d got %b exp %b", w, c, load_if.load_ready, exp_rdy); end
        vectors++; if (word_count !== exp_wc) begin miscompares++; $display("FAIL parity word_count w%0d cyc %0d got %0d exp %0d", w, c, word_count, exp_wc); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_random();
    test_mid_word_reset();
`ifdef SERIAL_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Upstream feed stage for the Mealy sequence detector: accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per `clk`, onto the detector's serial `x` input. It qualifies each bit with `x_valid` and counts completed words. Back-to-back words stream with no idle gap, so the detector sees a continuous bit sequence.

## Interface
- `WIDTH`, 8: data word width in bits; legal range 2..32.
- `IDLE_LEVEL`, 1'b0: value driven on `x` when no bit is being sent.
- `clk` input 1: rising-edge clock, shared with the detector.
- `reset` input 1: asynchronous, active-low reset. Low means reset.
- `load_data` input WIDTH: parallel word to serialize.
- `load_valid` input 1: `load_data` is valid this cycle.
- `load_ready` output 1: block accepts a word at this edge; combinational from state.
- `x` output 1: serial bit, registered; connects to the detector's `x`.
- `x_valid` output 1: `x` carries a live bit this cycle, registered.
- `word_count` output 16: number of completed words, registered, wraps.

## Operation
- Reset values:
  - FSM in IDLE.
  - `x` = IDLE_LEVEL, `x_valid` = 0, `word_count` = 0.
  - Shift register = 0, bit counter = 0.
  - `load_ready` = 0 while `reset` is low.
- Accept: a word is taken on a rising edge where `load_valid && load_ready`. While `load_ready` = 0, `load_data` is ignored; there is no hold-off buffer.
- States:
  - IDLE: `load_ready` = 1. On accept, go to SHIFT, drive `x` = `load_data[WIDTH-1]`, `x_valid` = 1, and set bit counter = WIDTH-1.
  - SHIFT: each edge drives the next lower bit and decrements the counter. When the counter is 0, the final data bit is on `x`:
    - If parity is compiled out: `load_ready` = 1 this cycle. On accept, load the new word's MSB at the next edge (no gap). Otherwise go to IDLE and drive `x` = IDLE_LEVEL, `x_valid` = 0.
    - If parity is compiled in: go to PARITY.
  - PARITY (only with the macro): `x` = even parity of the word, `x_valid` = 1, `load_ready` = 1. The next edge starts a new word on accept, otherwise goes to IDLE.
- `word_count` increments by 1 on the edge that retires the last bit of a word (data bit 0, or the parity bit when enabled). It wraps 16'hFFFF -> 0.
- Reset asserted mid-word: all state and outputs go immediately (asynchronously) to their reset values. The partial word is dropped and not counted.
- Parity is even over the WIDTH data bits, using the word as captured at accept.

## Timing
- Latency: accept edge N drives the MSB on `x` from after edge N, valid during cycle N+1. Bit i (MSB = 0) is valid in cycle N+1+i.
- A word occupies WIDTH cycles, or WIDTH+1 with parity.
- Sustained throughput: one word per WIDTH (or WIDTH+1) cycles with `load_valid` held high, with `x_valid` continuously 1.
- `x` is registered, so the detector samples each bit for exactly one full clock period.
- `load_ready` depends only on state and counter, never on `load_valid`. There is no combinational loop.

## Configuration
- `SERIAL_PARITY_EN`:
  - Defined: adds the PARITY state and appends one even-parity bit after each word. `load_ready` asserts in PARITY instead of on the last data bit.
  - Undefined: no PARITY state, words are pure WIDTH-bit streams, and `load_ready` asserts on the last data bit.

## Test plan
- Reset check: hold `reset` = 0 for 2 cycles, then release -> `x` = 0, `x_valid` = 0, `word_count` = 0, `load_ready` = 0 during reset and 1 after release.
- Single word: WIDTH=8, load 8'b0010_0100 for one cycle -> `x` = 0,0,1,0,0,1,0,0 on 8 consecutive cycles, `x_valid` = 1 for exactly 8 cycles, then `word_count` = 1 and `x` = IDLE_LEVEL.
- Back-to-back: load 8'hA5 then 8'h3C with `load_valid` held high -> 16 consecutive bits 1010_0101_0011_1100 with no `x_valid` gap, `word_count` = 2.
- Detector hookup: stream 8'b0010_0100, 8'b1010_0110 into the Mealy detector -> detector `z` pulses match the golden sequence model at the correct bit cycles.
- Mid-word reset: load 8'hFF, assert `reset` low after bit 3 -> `x_valid` drops immediately, `word_count` stays 0, and the next load after release starts at the MSB.
- Parity build with `SERIAL_PARITY_EN`: load 8'h07 -> 9 bits, last bit = 1; load 8'h03 -> last bit = 0. `load_ready` is high only in the parity cycle.
